// File: rtl/mem_stage.sv
// Memory stage of the 5-stage MIPS pipeline: latches execute results, issues the
// data-memory request and holds the pipeline until dhit.
module mem_stage #(
  parameter int unsigned WORD_W = 32,
  parameter int unsigned REG_W  = 5
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              ihit,
  input  logic              dhit,
  input  logic              flush,
  input  logic [WORD_W-1:0] ex_ALUOut,
  input  logic [WORD_W-1:0] ex_storeData,
  input  logic [WORD_W-1:0] ex_nPC,
  input  logic [WORD_W-1:0] ex_lui,
  input  logic [1:0]        ex_regSel,
  input  logic              ex_regWr,
  input  logic [REG_W-1:0]  ex_regDst,
  input  logic              ex_dREN,
  input  logic              ex_dWEN,
  input  logic              ex_halt,
  output logic              dmemREN,
  output logic              dmemWEN,
  output logic [WORD_W-1:0] dmemaddr,
  output logic [WORD_W-1:0] dmemstore,
  output logic              mem_stall,
  output logic [1:0]        regSel,
  output logic [WORD_W-1:0] nPC,
  output logic [WORD_W-1:0] ALUOut,
  output logic [WORD_W-1:0] lui,
  output logic              regWr,
  output logic [REG_W-1:0]  regDst,
  output logic [WORD_W-1:0] fwd_data,
  output logic              fwd_valid,
  output logic              load_hazard,
  output logic              halt
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]        state_q, state_d;
  logic              flush_pend_q, flush_pend_d;
  logic              capture, bubble, advance, in_req;
  logic [WORD_W-1:0] alu_q, store_q, npc_q, lui_q;
  logic [1:0]        regsel_q;
  logic              regwr_q;
  logic [REG_W-1:0]  regdst_q;
  logic              dren_q, dwen_q, halt_q;

  assign in_req    = (state_q == REQ);
  assign mem_stall = in_req & ~dhit;
  assign advance   = ihit & ~mem_stall;

  always_comb begin
    state_d      = state_q;
    flush_pend_d = flush_pend_q;
    capture      = 1'b0;
    bubble       = 1'b0;
    case (state_q)
      REQ: begin
        if (dhit) begin
          // A flush seen during the access kills the instruction once it completes.
          if (flush | flush_pend_q) begin
            bubble       = 1'b1;
            state_d      = IDLE;
            flush_pend_d = 1'b0;
          end else if (advance) begin
            capture = 1'b1;
          end else begin
            state_d = DONE;
          end
        end else if (flush) begin
          flush_pend_d = 1'b1;
        end
      end
      default: begin
        if (flush) begin
          bubble  = 1'b1;
          state_d = IDLE;
        end else if (advance) begin
          capture = 1'b1;
        end
      end
    endcase
    if (capture) begin
      state_d = (ex_dREN | ex_dWEN) ? REQ : IDLE;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q      <= IDLE;
      flush_pend_q <= 1'b0;
      alu_q        <= '0;
      store_q      <= '0;
      npc_q        <= '0;
      lui_q        <= '0;
      regsel_q     <= 2'd0;
      regwr_q      <= 1'b0;
      regdst_q     <= '0;
      dren_q       <= 1'b0;
      dwen_q       <= 1'b0;
      halt_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      flush_pend_q <= flush_pend_d;
      if (capture) begin
        alu_q    <= ex_ALUOut;
        store_q  <= ex_storeData;
        npc_q    <= ex_nPC;
        lui_q    <= ex_lui;
        regsel_q <= ex_regSel;
        regwr_q  <= ex_regWr;
        regdst_q <= ex_regDst;
        // Simultaneous read and write is treated as a store.
        dren_q   <= ex_dREN & ~ex_dWEN;
        dwen_q   <= ex_dWEN;
        halt_q   <= halt_q | ex_halt;
      end else if (bubble) begin
        regsel_q <= 2'd0;
        regwr_q  <= 1'b0;
        dren_q   <= 1'b0;
        dwen_q   <= 1'b0;
      end
    end
  end

  assign dmemREN   = in_req & dren_q & ~dwen_q;
  assign dmemWEN   = in_req & dwen_q;
  assign dmemaddr  = in_req ? alu_q : '0;
  assign dmemstore = in_req ? store_q : '0;

  assign regSel = regsel_q;
  assign nPC    = npc_q;
  assign ALUOut = alu_q;
  assign lui    = lui_q;
  assign regWr  = regwr_q;
  assign regDst = regdst_q;
  assign halt   = halt_q;

  always_comb begin
    fwd_data = '0;
    case (regsel_q)
      2'd0:    fwd_data = alu_q;
      2'd1:    fwd_data = npc_q;
      2'd2:    fwd_data = lui_q;
      default: fwd_data = '0;
    endcase
  end

  assign fwd_valid   = regwr_q & (regsel_q != 2'd3);
  assign load_hazard = regwr_q & (regsel_q == 2'd3);

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory pipeline stage of the 5-stage MIPS pipeline. Sits between execute and write-back.
- Latches execute results on pipeline advance and issues the latched data-memory request to the cache.
- Holds the pipeline until dhit, then forwards control/data to write-back. Also provides EX-stage forwarding info and the halt indication.

Parameters:
- WORD_W, 32, datapath width (word_t).
- REG_W, 5, register index width.

Ports:
- CLK  input  1  clock.
- nRST  input  1  asynchronous active-low reset.
- ihit  input  1  instruction hit; pipeline advance enable.
- dhit  input  1  data hit; current dmem access completes this cycle.
- flush  input  1  synchronous flush; turns the latched instruction into a bubble.
- ex_ALUOut  input  WORD_W  ALU result (also dmem address).
- ex_storeData  input  WORD_W  store data.
- ex_nPC  input  WORD_W  PC+4 for jal.
- ex_lui  input  WORD_W  lui value.
- ex_regSel  input  2  write-back source select (0 alu, 1 nPC, 2 lui, 3 load).
- ex_regWr  input  1  register write enable.
- ex_regDst  input  REG_W  destination register.
- ex_dREN  input  1  load.
- ex_dWEN  input  1  store.
- ex_halt  input  1  halt instruction.
- dmemREN  output  1  data read request.
- dmemWEN  output  1  data write request.
- dmemaddr  output  WORD_W  data address.
- dmemstore  output  WORD_W  store data.
- mem_stall  output  1  freeze upstream stages.
- regSel  output  2  to write-back.
- nPC  output  WORD_W  to write-back.
- ALUOut  output  WORD_W  to write-back.
- lui  output  WORD_W  to write-back.
- regWr  output  1  to write-back.
- regDst  output  REG_W  to write-back.
- fwd_data  output  WORD_W  forwardable value of the latched instruction.
- fwd_valid  output  1  fwd_data usable (regWr and regSel != 3).
- load_hazard  output  1  latched instruction is a load with regWr=1.
- halt  output  1  sticky halt.

Behaviour:
- Reset: all latched registers, outputs and halt go to 0; state IDLE; flush_pend 0.
- advance = ihit & ~mem_stall.
- On advance, capture all ex_* fields in one cycle.
  - If ex_dREN|ex_dWEN, next state is REQ; otherwise IDLE.
  - ex_dREN and ex_dWEN both high: treat as store only.
- States:
  - IDLE: no access outstanding.
  - REQ: access outstanding.
  - DONE: access completed, waiting for ihit.
- REQ: dmemREN = latched dREN & ~dWEN, dmemWEN = latched dWEN, dmemaddr = ALUOut, dmemstore = storeData. Request outputs are 0 in IDLE and DONE.
  - REQ & dhit & ihit: advance in the same cycle; next state per the newly captured instruction.
  - REQ & dhit & ~ihit: go to DONE.
  - REQ & ~dhit: stay in REQ.
- DONE: on ihit, advance.
- mem_stall = (state==REQ) & ~dhit. Combinational; it never depends on ihit.
- Flush:
  - In IDLE or DONE, flush has priority over advance. It zeroes regWr, dREN, dWEN, halt-capture and regSel; state goes IDLE.
  - In REQ, flush is recorded in flush_pend and the access runs to completion. No request is dropped mid-flight.
  - On dhit with flush_pend set: apply the bubble, clear flush_pend, go IDLE.
- fwd_data mux: regSel 0 gives ALUOut, 1 gives nPC, 2 gives lui, 3 gives 0.
- load_hazard = regWr & (regSel==3); it is valid in every state.
- halt: set when a latched instruction with halt=1 reaches this stage (IDLE after capture). It stays set until nRST; later flushes do not clear it.
- Asynchronous reset in REQ: requests drop immediately and state goes IDLE.

Test Plan:
- Reset: nRST=0 with ex_* nonzero → all outputs 0, mem_stall=0; release with ihit=0 → outputs still 0.
- ALU op: ex_ALUOut=0x1234, regSel=0, regWr=1, regDst=5, ihit=1 → next cycle ALUOut=0x1234, regDst=5, fwd_valid=1, fwd_data=0x1234, dmemREN=0.
- Load with 3-cycle dhit delay: ex_dREN=1, ex_ALUOut=0x40, ihit=1 → dmemREN=1, dmemaddr=0x40, mem_stall=1 for 2 cycles; load_hazard=1; at dhit, mem_stall=0 and request drops after advance.
- dhit without ihit: store to 0x80 with data 0xDEADBEEF; dhit arrives while ihit=0 → state DONE, dmemWEN=0, mem_stall=0; next ihit advances cleanly.
- Flush during REQ: load outstanding, flush pulse, dhit 2 cycles later → dmemREN held until dhit, then regWr=0, regSel=0, state IDLE.
- Halt: halt instruction advanced, followed by a flush → halt=1 and stays 1 until nRST.
